ordenador_caminho: RTL and testbench

Path reorder/stream stage downstream of the pathfinding core. Captures the node addresses the previous-node manager emits while building the path, which arrive destination-first. Re-emits them source-first on a valid/ready stream for the host side. Buffers one complete path in an internal LIFO and reports its length and error conditions.

---
 rtl/ordenador_caminho.sv | 137 +++++++++++++
 tb/tb_ordenador_caminho.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ordenador_caminho.sv
// Path reorder stage: captures path nodes destination-first into a LIFO and
// re-streams them source-first on a valid/ready interface.
module ordenador_caminho #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned MAX_CAMINHO = 256,
  parameter int unsigned PTR_WIDTH   = $clog2(MAX_CAMINHO)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_reset_in,
  input  logic                  no_valido_in,
  input  logic [ADDR_WIDTH-1:0] no_addr_in,
  input  logic                  caminho_fim_in,
  output logic                  out_valid_out,
  output logic [ADDR_WIDTH-1:0] out_addr_out,
  output logic                  out_ultimo_out,
  input  logic                  out_ready_in,
  output logic [PTR_WIDTH:0]    comprimento_out,
  output logic                  ocupado_out,
  output logic                  overflow_out,
  output logic                  erro_out
);

  typedef enum logic [1:0] {OCIOSO, CAPTURA, ENVIO} estado_t;

  localparam logic [PTR_WIDTH:0] PTR_MAX = (PTR_WIDTH+1)'(MAX_CAMINHO);
  localparam logic [PTR_WIDTH:0] UM      = (PTR_WIDTH+1)'(1);

  estado_t estado_q, estado_d;

  logic [PTR_WIDTH:0]    ptr_q, ptr_d, ptr_cap, ptr_menos_um;
  logic [PTR_WIDTH:0]    comp_d;
  logic                  valid_d, ultimo_d, ovf_d, erro_d;
  logic                  wr_en, rd_en;
  logic [PTR_WIDTH-1:0]  wr_idx, rd_idx;
  logic [ADDR_WIDTH-1:0] mem [MAX_CAMINHO];

  assign ptr_menos_um = ptr_q - UM;
  assign wr_idx       = ptr_q[PTR_WIDTH-1:0];
  assign rd_idx       = ptr_menos_um[PTR_WIDTH-1:0];
  assign ocupado_out  = (estado_q != OCIOSO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= OCIOSO;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    ptr_cap  = ptr_q;
    comp_d   = comprimento_out;
    valid_d  = out_valid_out;
    ultimo_d = out_ultimo_out;
    ovf_d    = overflow_out;
    erro_d   = erro_out;
    wr_en    = 1'b0;
    rd_en    = 1'b0;

    unique case (estado_q)
      OCIOSO, CAPTURA: begin
        // ptr is always 0 in OCIOSO, so both states share the capture path
        if (no_valido_in) begin
          if (ptr_q < PTR_MAX) begin
            wr_en   = 1'b1;
            ptr_cap = ptr_q + UM;
          end else begin
            ovf_d = 1'b1;
          end
          if (estado_q == OCIOSO) comp_d = '0;
        end
        ptr_d = ptr_cap;
        if (caminho_fim_in) begin
          comp_d = ptr_cap;
          if (ptr_cap != '0) estado_d = ENVIO;
        end else if (no_valido_in) begin
          estado_d = CAPTURA;
        end
      end
      ENVIO: begin
        if (no_valido_in) erro_d = 1'b1;
        // The read register is the output register: a read is issued whenever
        // the output slot is empty or being consumed, giving bubble-free beats.
        if (!out_valid_out || out_ready_in) begin
          if (ptr_q != '0) begin
            rd_en    = 1'b1;
            ptr_d    = ptr_menos_um;
            valid_d  = 1'b1;
            ultimo_d = (ptr_q == UM);
          end else begin
            valid_d  = 1'b0;
            ultimo_d = 1'b0;
            estado_d = OCIOSO;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase

    if (soft_reset_in) begin
      estado_d = OCIOSO;
      ptr_d    = '0;
      comp_d   = '0;
      valid_d  = 1'b0;
      ultimo_d = 1'b0;
      ovf_d    = 1'b0;
      erro_d   = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q           <= '0;
      comprimento_out <= '0;
      out_valid_out   <= 1'b0;
      out_ultimo_out  <= 1'b0;
      overflow_out    <= 1'b0;
      erro_out        <= 1'b0;
      out_addr_out    <= '0;
    end else begin
      ptr_q           <= ptr_d;
      comprimento_out <= comp_d;
      out_valid_out   <= valid_d;
      out_ultimo_out  <= ultimo_d;
      overflow_out    <= ovf_d;
      erro_out        <= erro_d;
      if (rd_en) out_addr_out <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= no_addr_in;
  end

endmodule

// File: tb/tb_ordenador_caminho.sv
// Self-checking bench for ordenador_caminho against a queue-based path model.
module tb_ordenador_caminho;

  localparam int unsigned AW   = 12;
  localparam int unsigned MAXC = 256;
  localparam int unsigned PW   = $clog2(MAXC);

  logic          clk, rst_n, soft_reset_in, no_valido_in, caminho_fim_in, out_ready_in;
  logic [AW-1:0] no_addr_in, out_addr_out;
  logic          out_valid_out, out_ultimo_out, ocupado_out, overflow_out, erro_out;
  logic [PW:0]   comprimento_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: captured nodes in arrival order, expected beat order, flags
  logic [AW-1:0] cap_q[$];
  logic [AW-1:0] exp_q[$];
  int            exp_len = 0;
  bit            exp_ovf = 0;
  bit            exp_err = 0;
  bit            in_envio = 0;

  ordenador_caminho #(.ADDR_WIDTH(AW), .MAX_CAMINHO(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .soft_reset_in(soft_reset_in),
    .no_valido_in(no_valido_in), .no_addr_in(no_addr_in),
    .caminho_fim_in(caminho_fim_in), .out_valid_out(out_valid_out),
    .out_addr_out(out_addr_out), .out_ultimo_out(out_ultimo_out),
    .out_ready_in(out_ready_in), .comprimento_out(comprimento_out),
    .ocupado_out(ocupado_out), .overflow_out(overflow_out), .erro_out(erro_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_node(input logic [AW-1:0] a);
    if (in_envio) exp_err = 1'b1;
    else if (cap_q.size() < MAXC) cap_q.push_back(a);
    else exp_ovf = 1'b1;
  endtask

  task automatic model_fim();
    exp_q.delete();
    foreach (cap_q[i]) exp_q.push_front(cap_q[i]);
    exp_len = cap_q.size();
    cap_q.delete();
    in_envio = (exp_len > 0);
  endtask

  task automatic send_node(input logic [AW-1:0] a);
    no_valido_in = 1'b1;
    no_addr_in   = a;
    model_node(a);
    @(negedge clk);
    no_valido_in = 1'b0;
  endtask

  task automatic send_fim(input bit with_node, input logic [AW-1:0] a);
    caminho_fim_in = 1'b1;
    if (with_node) begin
      no_valido_in = 1'b1;
      no_addr_in   = a;
      model_node(a);
    end
    model_fim();
    @(negedge clk);
    caminho_fim_in = 1'b0;
    no_valido_in   = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_overflow"}, 32'(overflow_out), 32'(exp_ovf));
    chk({tag, "_erro"}, 32'(erro_out), 32'(exp_err));
    chk({tag, "_comprimento"}, 32'(comprimento_out), 32'(exp_len));
  endtask

  // Consumes beats from the current negedge; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  // stop_after>0 returns after that many handshakes.
  task automatic run_stream(input int mode, input int stop_after, output int ncyc);
    int            taken;
    bit            done, stall, rdy;
    logic [AW-1:0] pa;
    logic          pu;
    taken = 0; done = 0; stall = 0; ncyc = 0; pa = '0; pu = 1'b0;
    while (!done && ncyc < 4000) begin
      if (stall) begin
        chk("stall_valid", 32'(out_valid_out), 32'd1);
        chk("stall_addr", 32'(out_addr_out), 32'(pa));
        chk("stall_ultimo", 32'(out_ultimo_out), 32'(pu));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (ncyc % 4 == 0) || (ncyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready_in = rdy;
      stall = out_valid_out && !rdy;
      pa    = out_addr_out;
      pu    = out_ultimo_out;
      if (out_valid_out && rdy) begin
        if (taken < exp_q.size()) begin
          chk("beat_addr", 32'(out_addr_out), 32'(exp_q[taken]));
          chk("beat_ultimo", 32'(out_ultimo_out), 32'(taken == exp_q.size() - 1));
        end else begin
          chk("beat_count", 32'(taken + 1), 32'(exp_q.size()));
        end
        taken++;
        if (out_ultimo_out) begin
          done = 1'b1;
          in_envio = 1'b0;
        end else if (taken == stop_after) begin
          done = 1'b1;
        end
      end
      ncyc++;
      @(negedge clk);
    end
    chk("stream_done", 32'(done), 32'd1);
    if (stop_after == 0) chk("beat_count", 32'(taken), 32'(exp_q.size()));
    out_ready_in = 1'b0;
  endtask

  initial begin
    int            nc;
    int            len;
    logic [AW-1:0] a;

    rst_n = 1'b0; soft_reset_in = 1'b0; no_valido_in = 1'b0; no_addr_in = '0;
    caminho_fim_in = 1'b0; out_ready_in = 1'b0;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(out_valid_out), 32'd0);
    chk("rst_addr", 32'(out_addr_out), 32'd0);
    chk("rst_ultimo", 32'(out_ultimo_out), 32'd0);
    chk("rst_comprimento", 32'(comprimento_out), 32'd0);
    chk("rst_ocupado", 32'(ocupado_out), 32'd0);
    chk("rst_overflow", 32'(overflow_out), 32'd0);
    chk("rst_erro", 32'(erro_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 3-node path, ready held high: latency and throughput
    out_ready_in = 1'b1;
    send_node(12'h005);
    chk("t1_ocupado_rise", 32'(ocupado_out), 32'd1);
    send_node(12'h004);
    send_node(12'h003);
    send_fim(1'b0, '0);
    chk("t1_valid_fim1", 32'(out_valid_out), 32'd0);
    chk("t1_ocupado", 32'(ocupado_out), 32'd1);
    chk_flags("t1");
    @(negedge clk);
    chk("t1_valid_fim2", 32'(out_valid_out), 32'd1);
    chk("t1_first_addr", 32'(out_addr_out), 32'h003);
    run_stream(0, 0, nc);
    chk("t1_throughput", 32'(nc), 32'd3);
    chk("t1_ocupado_fall", 32'(ocupado_out), 32'd0);
    chk("t1_valid_after", 32'(out_valid_out), 32'd0);
    chk_flags("t1_after");

    // Same path with ready pattern 1,0,0,1
    send_node(12'h005);
    send_node(12'h004);
    send_node(12'h003);
    send_fim(1'b0, '0);
    run_stream(1, 0, nc);
    chk("t2_ocupado_fall", 32'(ocupado_out), 32'd0);
    chk_flags("t2");

    // Random paths with gaps, random ready, optional node+fim in the same cycle
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(1, 20));
      for (int k = 0; k < len - 1; k++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_node(AW'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        send_fim(1'b1, AW'($urandom));
      end else begin
        send_node(AW'($urandom));
        send_fim(1'b0, '0);
      end
      chk_flags("rnd_fim");
      run_stream(2, 0, nc);
      chk("rnd_ocupado_fall", 32'(ocupado_out), 32'd0);
      chk_flags("rnd_after");
    end

    // Node and fim in the same cycle as the 2nd node
    send_node(12'hA11);
    send_fim(1'b1, 12'hB22);
    chk("same_comprimento", 32'(comprimento_out), 32'd2);
    run_stream(0, 0, nc);
    chk_flags("same");

    // Overflow: MAXC+2 nodes
    for (int k = 0; k < int'(MAXC); k++) send_node(AW'($urandom));
    chk("ovf_at_full", 32'(overflow_out), 32'(exp_ovf));
    send_node(AW'($urandom));
    send_node(AW'($urandom));
    chk("ovf_set", 32'(overflow_out), 32'd1);
    send_fim(1'b0, '0);
    chk("ovf_comprimento", 32'(comprimento_out), 32'(MAXC));
    run_stream(2, 0, nc);
    chk_flags("ovf_after");

    // Soft reset mid-ENVIO with beats pending, plus a node dropped during ENVIO
    send_node(12'h111);
    send_node(12'h222);
    send_node(12'h333);
    send_node(12'h444);
    send_fim(1'b0, '0);
    send_node(12'hABC);
    chk("sr_erro_set", 32'(erro_out), 32'd1);
    run_stream(0, 2, nc);
    soft_reset_in = 1'b1;
    cap_q.delete(); exp_q.delete();
    exp_len = 0; exp_ovf = 1'b0; exp_err = 1'b0; in_envio = 1'b0;
    @(negedge clk);
    soft_reset_in = 1'b0;
    chk("sr_valid", 32'(out_valid_out), 32'd0);
    chk("sr_ocupado", 32'(ocupado_out), 32'd0);
    chk_flags("sr");
    @(negedge clk);
    chk("sr_valid_hold", 32'(out_valid_out), 32'd0);
    a = AW'($urandom);
    send_node(a);
    send_fim(1'b0, '0);
    @(negedge clk);
    chk("sr_new_ultimo", 32'(out_ultimo_out), 32'd1);
    run_stream(0, 0, nc);
    chk_flags("sr_new");

    // fim with no nodes: no beats, comprimento 0
    send_fim(1'b0, '0);
    chk("empty_valid", 32'(out_valid_out), 32'd0);
    chk("empty_ocupado", 32'(ocupado_out), 32'd0);
    chk_flags("empty");
    @(negedge clk); @(negedge clk);
    chk("empty_valid_later", 32'(out_valid_out), 32'd0);

    // Node during ENVIO: erro set, stream unchanged
    send_node(12'h0C1);
    send_node(12'h0C2);
    send_node(12'h0C3);
    send_fim(1'b0, '0);
    send_node(12'hFFF);
    chk("erro_set", 32'(erro_out), 32'd1);
    run_stream(1, 0, nc);
    chk_flags("erro_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
